// File: rtl/chain_mod.sv
`default_nettype none
// ============================================================================
// Module   : chain_mod
// Brief    : Systolic fixed-point multiply-accumulate processing element.
//            Optional macro CHAIN_MOD_SATURATE_EN clamps product and sum.
// Revision : 1.0 - initial release
// ============================================================================
module chain_mod #(
    parameter int BIT_RES   = 32,
    parameter int FRAC_BITS = 23
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BIT_RES-1:0] numInSide,
    output logic [BIT_RES-1:0] numOutSide,
    input  logic [BIT_RES-1:0] numInTop,
    output logic [BIT_RES-1:0] numOutTop,
    output logic [BIT_RES-1:0] sum
);

`ifdef CHAIN_MOD_SATURATE_EN
    localparam logic [BIT_RES-1:0] c_MAX = {1'b0, {(BIT_RES-1){1'b1}}};
    localparam logic [BIT_RES-1:0] c_MIN = {1'b1, {(BIT_RES-1){1'b0}}};
`endif

    logic [BIT_RES-1:0]          r_side;
    logic [BIT_RES-1:0]          r_top;
    logic [BIT_RES-1:0]          r_sum;
    logic signed [2*BIT_RES-1:0] w_prodFull;
    logic signed [2*BIT_RES-1:0] w_prodShift;
    logic [BIT_RES-1:0]          w_prod;
    logic [BIT_RES:0]            w_sumWide;
    logic [BIT_RES-1:0]          w_sumNext;

    assign w_prodFull  = (2*BIT_RES)'($signed(numInSide)) * (2*BIT_RES)'($signed(numInTop));
    // Arithmetic shift of the signed product gives floor (toward -inf) rounding.
    assign w_prodShift = w_prodFull >>> FRAC_BITS;
    assign w_sumWide   = {r_sum[BIT_RES-1], r_sum} + {w_prod[BIT_RES-1], w_prod};

    always_comb begin
`ifdef CHAIN_MOD_SATURATE_EN
        w_prod = w_prodShift[BIT_RES-1:0];
        // Upper bits not all copies of the sign bit means the product left the range.
        if (w_prodShift[2*BIT_RES-1:BIT_RES-1] != {(BIT_RES+1){w_prodShift[2*BIT_RES-1]}}) begin
            w_prod = w_prodShift[2*BIT_RES-1] ? c_MIN : c_MAX;
        end
        w_sumNext = w_sumWide[BIT_RES-1:0];
        if (w_sumWide[BIT_RES] != w_sumWide[BIT_RES-1]) begin
            w_sumNext = w_sumWide[BIT_RES] ? c_MIN : c_MAX;
        end
`else
        w_prod    = BIT_RES'(w_prodShift);
        w_sumNext = BIT_RES'(w_sumWide);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_side <= '0;
            r_top  <= '0;
            r_sum  <= '0;
        end else begin
            r_side <= numInSide;
            r_top  <= numInTop;
            r_sum  <= w_sumNext;
        end
    end

    assign numOutSide = r_side;
    assign numOutTop  = r_top;
    assign sum        = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_chain_mod.sv
`default_nettype none
// ============================================================================
// Module   : tb_chain_mod
// Brief    : Self-checking bench for chain_mod against an integer-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chain_mod;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] numInSide;
    logic [31:0] numOutSide;
    logic [31:0] numInTop;
    logic [31:0] numOutTop;
    logic [31:0] sum;

    int checks = 0;
    int errors = 0;

    // Reference state: real-number semantics with 64-bit integers.
    longint mSum  = 0;
    logic [31:0] mSide = '0;
    logic [31:0] mTop  = '0;

    chain_mod #(.BIT_RES(32), .FRAC_BITS(23)) dut (
        .clk        (clk),
        .reset      (reset),
        .numInSide  (numInSide),
        .numOutSide (numOutSide),
        .numInTop   (numInTop),
        .numOutTop  (numOutTop),
        .sum        (sum)
    );

    always #5 clk = ~clk;

    function automatic longint clamp32(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input logic [31:0] a, input logic [31:0] b, input logic rst);
        longint p;
        if (rst) begin
            mSum = 0; mSide = '0; mTop = '0;
        end else begin
            // Exact product, then floor-divide by 2^FRAC_BITS.
            p = (longint'($signed(a)) * longint'($signed(b))) >>> 23;
`ifdef CHAIN_MOD_SATURATE_EN
            mSum = clamp32(mSum + clamp32(p));
`else
            mSum = longint'($signed(32'(mSum + longint'($signed(32'(p))))));
`endif
            mSide = a;
            mTop  = b;
        end
    endtask

    task automatic cycle(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic rst);
        numInSide = a;
        numInTop  = b;
        reset     = rst;
        @(posedge clk);
        #1;
        modelStep(a, b, rst);
        chk({tag, "_sum"},  sum,        32'(mSum));
        chk({tag, "_side"}, numOutSide, mSide);
        chk({tag, "_top"},  numOutTop,  mTop);
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset = 1'b1; numInSide = '0; numInTop = '0;

        cycle("rst", 32'h0, 32'h0, 1'b1);
        chk("rst_sum0", sum, 32'h0);

        cycle("m2x3", 32'h01000000, 32'h01800000, 1'b0);
        chk("m2x3_lit", sum, 32'h03000000);
        chk("m2x3_side_lit", numOutSide, 32'h01000000);
        cycle("m2x3_idle", 32'h0, 32'h0, 1'b0);
        chk("m2x3_idle_lit", sum, 32'h03000000);

        cycle("ones_rst", 32'h0, 32'h0, 1'b1);
        cycle("ones1", 32'h00800000, 32'h00800000, 1'b0);
        chk("ones1_lit", sum, 32'h00800000);
        cycle("ones2", 32'h00800000, 32'h00800000, 1'b0);
        chk("ones2_lit", sum, 32'h01000000);
        cycle("ones3", 32'h00800000, 32'h00800000, 1'b0);
        chk("ones3_lit", sum, 32'h01800000);

        // Reset mid-accumulation with live operands discards them.
        cycle("midrst", 32'h00800000, 32'h00800000, 1'b1);
        chk("midrst_lit", sum, 32'h0);
        cycle("afterrst", 32'h00800000, 32'h00800000, 1'b0);
        chk("afterrst_lit", sum, 32'h00800000);

        cycle("neg_rst", 32'h0, 32'h0, 1'b1);
        cycle("neg", 32'hFF400000, 32'h01000000, 1'b0);
        chk("neg_lit", sum, 32'hFE800000);

        cycle("rnd_rst", 32'h0, 32'h0, 1'b1);
        cycle("tiny", 32'h00000001, 32'h00000001, 1'b0);
        chk("tiny_lit", sum, 32'h0);
        cycle("floor_rst", 32'h0, 32'h0, 1'b1);
        cycle("floor", 32'hFFFFFFFF, 32'h00000001, 1'b0);
        chk("floor_lit", sum, 32'hFFFFFFFF);

        cycle("big_rst", 32'h0, 32'h0, 1'b1);
        cycle("big1", 32'h32000000, 32'h32000000, 1'b0);
`ifdef CHAIN_MOD_SATURATE_EN
        chk("big1_lit", sum, 32'h7FFFFFFF);
        cycle("big2", 32'h32000000, 32'h32000000, 1'b0);
        chk("big2_lit", sum, 32'h7FFFFFFF);
`else
        chk("big1_lit", sum, 32'h88000000);
`endif

        cycle("z_rst", 32'h0, 32'h0, 1'b1);
        cycle("z_a", 32'h00800000, 32'h00800000, 1'b0);
        cycle("z_b", 32'h00800000, 32'h0, 1'b0);
        chk("z_b_lit", sum, 32'h00800000);
        cycle("z_c", 32'h0, 32'h02800000, 1'b0);
        chk("z_c_lit", sum, 32'h00800000);
        chk("z_c_top_lit", numOutTop, 32'h02800000);

        // Random mix of fractional-range and full-range operands, occasional reset.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                ra = 32'($signed($urandom_range(0, 32'h04000000)) - 32'sh02000000);
                rb = 32'($signed($urandom_range(0, 32'h04000000)) - 32'sh02000000);
            end else begin
                ra = $urandom;
                rb = $urandom;
            end
            if ($urandom_range(0, 7) == 0) ra = '0;
            cycle("rand", ra, rb, $urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
